time_base_timer: RTL and testbench

- Parametrised time base for the receiver clock domain.
- Derives 1 us, 1 ms and 1 s single-cycle ticks from CLK_FREQ.
- Provides NUM_CH independent ms-resolution interval timers with one-shot and periodic modes.
- Replaces ad-hoc per-block tick counters; downstream logic uses the ticks as clock enables and the channel expiries as timeout events.

---
 rtl/time_base_timer.sv | 192 +++++++++++++++++++
 tb/tb_time_base_timer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_base_timer.sv
// time_base_timer
//   Time base for the receiver clock domain. A prescaler divides clk down to
//   1 us, then cascaded decimal counters derive 1 ms and 1 s. Each tick is a
//   registered single-cycle pulse intended as a clock enable. NUM_CH
//   independent ms-resolution interval timers provide one-shot or periodic
//   timeout events.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   run          global enable; 0 freezes prescaler, us/ms counters and channel counts
//   us_tick      one-cycle pulse every 1 us
//   ms_tick      one-cycle pulse every 1 ms
//   s_tick       one-cycle pulse every 1 s
//   ch_start     per-channel start/restart pulse (samples ch_periodic, ch_period)
//   ch_stop      per-channel stop pulse (highest priority)
//   ch_periodic  per-channel mode: 1 = auto-reload, 0 = one-shot
//   ch_period    packed periods in ms, channel i at [i*PERIOD_W +: PERIOD_W]
//   ch_busy      channel is counting
//   ch_expire    one-cycle expiry pulse, aligned with ms_tick
//   ch_flag      sticky expiry flag
//   ch_ack       clears ch_flag (an expiry in the same cycle wins)
module time_base_timer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    output logic                         us_tick,
    output logic                         ms_tick,
    output logic                         s_tick,
    input  logic [NUM_CH-1:0]            ch_start,
    input  logic [NUM_CH-1:0]            ch_stop,
    input  logic [NUM_CH-1:0]            ch_periodic,
    input  logic [NUM_CH*PERIOD_W-1:0]   ch_period,
    output logic [NUM_CH-1:0]            ch_busy,
    output logic [NUM_CH-1:0]            ch_expire,
    output logic [NUM_CH-1:0]            ch_flag,
    input  logic [NUM_CH-1:0]            ch_ack
);

    localparam int DIV = CLK_FREQ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PERIOD_W-1:0] ONE_MS  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] ZERO_MS = {PERIOD_W{1'b0}};

    logic [PW-1:0] presc_r;
    logic [9:0]    us_cnt_r;
    logic [9:0]    ms_cnt_r;
    logic          us_stb_s;
    logic          ms_stb_s;
    logic          s_stb_s;
    logic          us_tick_r;
    logic          ms_tick_r;
    logic          s_tick_r;

    // Strobe decode: each stage fires on the terminal count of every stage below it.
    always_comb begin
        us_stb_s = run && (presc_r == PW'(DIV - 1));
        ms_stb_s = us_stb_s && (us_cnt_r == 10'd999);
        s_stb_s  = ms_stb_s && (ms_cnt_r == 10'd999);
    end

    // Prescaler: 0..DIV-1 while run, holds its phase while run is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PW{1'b0}};
        end else if (run) begin
            if (presc_r == PW'(DIV - 1)) begin
                presc_r <= {PW{1'b0}};
            end else begin
                presc_r <= presc_r + PW'(1'b1);
            end
        end
    end

    // Microsecond counter 0..999, advances on each us strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt_r <= 10'd0;
        end else if (us_stb_s) begin
            if (us_cnt_r == 10'd999) begin
                us_cnt_r <= 10'd0;
            end else begin
                us_cnt_r <= us_cnt_r + 10'd1;
            end
        end
    end

    // Millisecond counter 0..999, advances on each ms strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt_r <= 10'd0;
        end else if (ms_stb_s) begin
            if (ms_cnt_r == 10'd999) begin
                ms_cnt_r <= 10'd0;
            end else begin
                ms_cnt_r <= ms_cnt_r + 10'd1;
            end
        end
    end

    // Registered tick outputs, one cycle behind the internal strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_tick_r <= 1'b0;
            ms_tick_r <= 1'b0;
            s_tick_r  <= 1'b0;
        end else begin
            us_tick_r <= us_stb_s;
            ms_tick_r <= ms_stb_s;
            s_tick_r  <= s_stb_s;
        end
    end

    assign us_tick = us_tick_r;
    assign ms_tick = ms_tick_r;
    assign s_tick  = s_tick_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : ch_g
        logic [PERIOD_W-1:0] period_s;
        logic                load_s;
        logic                expire_s;
        logic                busy_r;
        logic                periodic_r;
        logic                expire_r;
        logic                flag_r;
        logic [PERIOD_W-1:0] remaining_r;
        logic [PERIOD_W-1:0] period_r;

        assign period_s = ch_period[i*PERIOD_W +: PERIOD_W];

        // Decode this cycle's channel event; stop beats start beats the ms strobe.
        always_comb begin
            load_s   = ch_start[i] && (period_s != ZERO_MS);
            expire_s = 1'b0;
            if (!ch_stop[i] && !load_s && ms_stb_s && busy_r && (remaining_r == ONE_MS)) begin
                expire_s = 1'b1;
            end else begin
                expire_s = 1'b0;
            end
        end

        // Channel counter: remaining never goes below 1 while busy; a periodic
        // channel reloads on expiry, a one-shot channel goes idle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy_r      <= 1'b0;
                periodic_r  <= 1'b0;
                remaining_r <= ZERO_MS;
                period_r    <= ZERO_MS;
            end else if (ch_stop[i]) begin
                busy_r <= 1'b0;
            end else if (load_s) begin
                busy_r      <= 1'b1;
                periodic_r  <= ch_periodic[i];
                remaining_r <= period_s;
                period_r    <= period_s;
            end else if (expire_s) begin
                if (periodic_r) begin
                    remaining_r <= period_r;
                end else begin
                    busy_r <= 1'b0;
                end
            end else if (ms_stb_s && busy_r) begin
                remaining_r <= remaining_r - ONE_MS;
            end
        end

        // Expiry pulse and sticky flag; a same-cycle ack loses against a new expiry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                expire_r <= 1'b0;
                flag_r   <= 1'b0;
            end else begin
                expire_r <= expire_s;
                if (expire_s) begin
                    flag_r <= 1'b1;
                end else if (ch_ack[i]) begin
                    flag_r <= 1'b0;
                end
            end
        end

        assign ch_busy[i]   = busy_r;
        assign ch_expire[i] = expire_r;
        assign ch_flag[i]   = flag_r;
    end

endmodule

// File: tb/tb_time_base_timer.sv
module tb_time_base_timer;

    localparam int CLK_FREQ = 4_000_000;
    localparam int DIV      = CLK_FREQ / 1_000_000;
    localparam int MS       = DIV * 1000;
    localparam int SC       = DIV * 1000000;
    localparam int NUM_CH   = 4;
    localparam int PERIOD_W = 16;

    logic                       clk;
    logic                       rst_n;
    logic                       run;
    logic                       us_tick;
    logic                       ms_tick;
    logic                       s_tick;
    logic [NUM_CH-1:0]          ch_start;
    logic [NUM_CH-1:0]          ch_stop;
    logic [NUM_CH-1:0]          ch_periodic;
    logic [NUM_CH*PERIOD_W-1:0] ch_period;
    logic [NUM_CH-1:0]          ch_busy;
    logic [NUM_CH-1:0]          ch_expire;
    logic [NUM_CH-1:0]          ch_flag;
    logic [NUM_CH-1:0]          ch_ack;

    typedef struct {
        int ch;
        int ms;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   run_edges = 0;
    logic last_run = 1'b0;

    time_base_timer #(.CLK_FREQ(CLK_FREQ), .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .us_tick(us_tick), .ms_tick(ms_tick), .s_tick(s_tick),
        .ch_start(ch_start), .ch_stop(ch_stop), .ch_periodic(ch_periodic),
        .ch_period(ch_period), .ch_busy(ch_busy), .ch_expire(ch_expire),
        .ch_flag(ch_flag), .ch_ack(ch_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference time: number of clock edges that saw run=1 since reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_edges <= 0;
            last_run  <= 1'b0;
        end else begin
            last_run <= run;
            if (run) run_edges <= run_edges + 1;
        end
    end

    // Monitor: tick pattern from the run-edge count, expiries against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ticks", {29'd0, us_tick, ms_tick, s_tick}, 32'd0);
            chk("rst_ch", {20'd0, ch_busy, ch_expire, ch_flag}, 32'd0);
        end else begin
            chk("us_tick", {31'd0, us_tick}, {31'd0, last_run && run_edges > 0 && (run_edges % DIV) == 0});
            chk("ms_tick", {31'd0, ms_tick}, {31'd0, last_run && run_edges > 0 && (run_edges % MS) == 0});
            chk("s_tick", {31'd0, s_tick}, {31'd0, last_run && run_edges > 0 && (run_edges % SC) == 0});
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_expire[c]) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (idx < 0 && sb[k].ch == c) idx = k;
                    if (idx < 0) begin
                        chk("expire_unexpected", c, 32'hFFFF_FFFF);
                    end else begin
                        chk("expire_ms", run_edges / MS, sb[idx].ms);
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    // Advance (from the post-edge phase) until the reference time reaches target.
    task automatic go_to(input int target);
        int n;
        n = 0;
        while (run_edges < target && n < 100000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("go_to", run_edges, target);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input int c, input int m);
        exp_t e;
        e.ch = c;
        e.ms = m;
        sb.push_back(e);
    endtask

    task automatic drop_ch(input int c);
        for (int k = sb.size() - 1; k >= 0; k--)
            if (sb[k].ch == c) sb.delete(k);
    endtask

    initial begin
        int base;
        int n;
        rst_n = 1'b0; run = 1'b0;
        ch_start = '0; ch_stop = '0; ch_periodic = '0; ch_period = '0; ch_ack = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; run = 1'b1;

        // Run gating: 37-cycle hold mid-count, phase must carry over.
        go_to(50);
        run = 1'b0;
        repeat (37) step();
        run = 1'b1;

        // ms 1: ch0 one-shot 3, ch1 periodic 2, ch3 one-shot 3 (to be restarted).
        go_to(MS);
        chk("ms1_tick", {31'd0, ms_tick}, 32'd1);
        base = (run_edges + 1) / MS;
        ch_start = 4'b1011; ch_periodic = 4'b0010;
        ch_period[0*16 +: 16] = 16'd3;
        ch_period[1*16 +: 16] = 16'd2;
        ch_period[3*16 +: 16] = 16'd3;
        push(0, base + 3);
        for (int k = 1; k <= 5; k++) push(1, base + 2 * k);
        push(3, base + 3);
        step();
        ch_start = '0;
        chk("busy_after_start", {28'd0, ch_busy}, 32'h0000_000B);

        // ch2 start coincident with an ms strobe: that strobe is not counted.
        go_to(2 * MS - 1);
        base = (run_edges + 1) / MS;
        ch_start = 4'b0100; ch_periodic = 4'b0000;
        ch_period[2*16 +: 16] = 16'd2;
        push(2, base + 2);
        step();
        ch_start = '0;
        chk("coll_ms_tick", {31'd0, ms_tick}, 32'd1);
        chk("coll_busy2", {31'd0, ch_busy[2]}, 32'd1);

        // Restart ch3 while busy with a new period.
        go_to(2 * MS + 100);
        base = (run_edges + 1) / MS;
        ch_start = 4'b1000;
        ch_period[3*16 +: 16] = 16'd4;
        drop_ch(3);
        push(3, base + 4);
        step();
        ch_start = '0;

        // ms 4: ch0 and ch2 expire together; busy drops in the same cycle.
        go_to(4 * MS);
        chk("ms4_expire", {28'd0, ch_expire}, 32'h0000_0005);
        chk("ms4_busy", {28'd0, ch_busy}, 32'h0000_000A);
        chk("ms4_flag", {28'd0, ch_flag}, 32'h0000_0007);

        // Start with period 0 is ignored on both a busy and an idle channel.
        go_to(5 * MS + 10);
        ch_start = 4'b1100;
        ch_period[2*16 +: 16] = 16'd0;
        ch_period[3*16 +: 16] = 16'd0;
        step();
        ch_start = '0;
        chk("zero_period", {28'd0, ch_busy}, 32'h0000_000A);

        // Flags stay up until acked.
        go_to(6 * MS + 20);
        chk("flags_sticky", {28'd0, ch_flag}, 32'h0000_000F);
        ch_ack = 4'b0011;
        step();
        ch_ack = '0;
        chk("flags_acked", {28'd0, ch_flag}, 32'h0000_000C);

        go_to(7 * MS + 20);
        chk("flag1_reset", {31'd0, ch_flag[1]}, 32'd1);
        ch_ack = 4'b0010;
        step();
        ch_ack = '0;
        chk("flag1_clear", {31'd0, ch_flag[1]}, 32'd0);

        // Ack coincident with an expiry: set wins.
        go_to(9 * MS - 1);
        ch_ack = 4'b0010;
        step();
        ch_ack = '0;
        chk("ack_vs_expire", {31'd0, ch_flag[1]}, 32'd1);

        // Stop coincident with an expiring strobe: no expiry, channel idle.
        go_to(13 * MS - 1);
        ch_stop = 4'b0010;
        step();
        ch_stop = '0;
        chk("stop_ms_tick", {31'd0, ms_tick}, 32'd1);
        chk("stop_expire", {31'd0, ch_expire[1]}, 32'd0);
        chk("stop_busy", {31'd0, ch_busy[1]}, 32'd0);

        go_to(13 * MS + 10);
        chk("sb_empty", sb.size(), 32'd0);

        // Async reset mid-count with channels busy.
        ch_start = 4'b0011; ch_periodic = 4'b0011;
        ch_period[0*16 +: 16] = 16'hFFFF;
        ch_period[1*16 +: 16] = 16'd5;
        step();
        ch_start = '0;
        chk("pre_rst_busy", {28'd0, ch_busy}, 32'h0000_0003);
        go_to(13 * MS + 50);
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("async_rst_ticks", {29'd0, us_tick, ms_tick, s_tick}, 32'd0);
        chk("async_rst_ch", {20'd0, ch_busy, ch_expire, ch_flag}, 32'd0);
        #2;
        rst_n = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!us_tick && n < 20);
        chk("first_us_after_rst", n, DIV);
        repeat (3 * DIV) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
